// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice resolved per stage,
// with valid/ready flow control where the whole pipeline advances or holds together.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSTG = WIDTH / BLOCK;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
    $error("csel_adder_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  // Plain BLOCK-bit ripple; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] ripple(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             ci
  );
    logic [BLOCK:0] r;
    logic           cy;
    r  = '0;
    cy = ci;
    for (int i = 0; i < BLOCK; i++) begin
      r[i] = x[i] ^ y[i] ^ cy;
      cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    r[BLOCK] = cy;
    return r;
  endfunction

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [NSTG-1:0]  vld;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = cin ^ sub;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    // IW: operand bits still unresolved entering this stage; UW: bits passed on.
    localparam int IW = WIDTH - k * BLOCK;
    localparam int UW = IW - BLOCK;
    localparam int RW = (k + 1) * BLOCK;

    logic [IW-1:0]  a_in;
    logic [IW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;
    logic [BLOCK:0] rs;
    logic [RW-1:0]  s_d;
    logic [RW-1:0]  s_q;
    logic           c_q;
    logic           v_q;

    if (k == 0) begin : g_src
      assign a_in = a;
      assign b_in = b_eff;
      assign c_in = c_eff;
      assign v_in = in_valid;
      assign s_d  = rs[BLOCK-1:0];
    end else begin : g_src
      assign a_in = g_stg[k-1].g_up.a_q;
      assign b_in = g_stg[k-1].g_up.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;
      assign s_d  = {rs[BLOCK-1:0], g_stg[k-1].s_q};
    end

    // Both carry hypotheses are ready before the previous stage's carry arrives.
    assign r0 = ripple(a_in[BLOCK-1:0], b_in[BLOCK-1:0], 1'b0);
    assign r1 = ripple(a_in[BLOCK-1:0], b_in[BLOCK-1:0], 1'b1);
    assign rs = c_in ? r1 : r0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= rs[BLOCK];
        s_q <= s_d;
      end
    end

    if (UW > 0) begin : g_up
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[IW-1:BLOCK];
          b_q <= b_in[IW-1:BLOCK];
        end
      end
    end else begin : g_msb
      // Carry into the MSB, recovered from the MSB sum bit and its operands.
      logic cm_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cm_q <= 1'b0;
        end else if (advance) begin
          cm_q <= a_in[BLOCK-1] ^ b_in[BLOCK-1] ^ rs[BLOCK-1];
        end
      end
    end

    assign vld[k] = v_q;
  end

  assign out_valid = g_stg[NSTG-1].v_q;
  assign sum       = g_stg[NSTG-1].s_q;
  assign cout      = g_stg[NSTG-1].c_q;
  assign ovf       = g_stg[NSTG-1].g_msb.cm_q ^ g_stg[NSTG-1].c_q;
  assign busy      = |vld;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: three configurations (8/8, 16/4, 32/4) exercised in turn,
// checked against a table of known results and an arithmetic reference via a scoreboard.
module tb_csel_adder_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          cyc;
    int          holds;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cin_d;
  logic        sub_d;
  logic [31:0] a_d;
  logic [31:0] b_d;

  logic        iv8, ir8, ov8, co8, of8, bz8;
  logic        iv16, ir16, ov16, co16, of16, bz16;
  logic        iv32, ir32, ov32, co32, of32, bz32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;

  int          sel;
  int          cur_w;
  int          nstg;
  logic        s_in_ready, s_out_valid, s_cout, s_ovf, s_busy;
  logic [31:0] s_sum;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          holds = 0;
  logic        accepted;
  logic [31:0] exp_s;
  logic        exp_co;
  logic        exp_ov;
  exp_t        q[$];
  vec_t        tbl[10];

  always #5 clk = ~clk;

  assign iv8  = in_valid && (sel == 0);
  assign iv16 = in_valid && (sel == 1);
  assign iv32 = in_valid && (sel == 2);

  csel_adder_pipe #(.WIDTH(8), .BLOCK(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8), .busy(bz8)
  );

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a_d[15:0]), .b(b_d[15:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16), .busy(bz16)
  );

  csel_adder_pipe #(.WIDTH(32), .BLOCK(4)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
    .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32), .busy(bz32)
  );

  always_comb begin
    s_in_ready  = ir16;
    s_out_valid = ov16;
    s_sum       = {16'h0, s16};
    s_cout      = co16;
    s_ovf       = of16;
    s_busy      = bz16;
    if (sel == 0) begin
      s_in_ready  = ir8;
      s_out_valid = ov8;
      s_sum       = {24'h0, s8};
      s_cout      = co8;
      s_ovf       = of8;
      s_busy      = bz8;
    end else if (sel == 2) begin
      s_in_ready  = ir32;
      s_out_valid = ov32;
      s_sum       = s32;
      s_cout      = co32;
      s_ovf       = of32;
      s_busy      = bz32;
    end
  end

  function automatic logic [31:0] wmask(input int w);
    logic [31:0] one;
    one = 32'h1;
    return (w >= 32) ? 32'hFFFF_FFFF : ((one << w) - 32'h1);
  endfunction

  // Reference: straight integer add, overflow from operand/result signs.
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                       input logic sb, output logic [31:0] s, output logic co,
                       output logic ov);
    logic [32:0] t;
    logic [31:0] m, x, y;
    m  = wmask(cur_w);
    x  = av & m;
    y  = (sb ? ~bv : bv) & m;
    t  = {1'b0, x} + {1'b0, y} + {32'h0, ci ^ sb};
    s  = t[31:0] & m;
    co = t[cur_w];
    ov = (x[cur_w-1] == y[cur_w-1]) && (s[cur_w-1] != x[cur_w-1]);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s (width %0d): got %h, expected %h", nm, cur_w, act, expv);
    end
  endtask

  // One cycle: called at a negedge with inputs already driven.
  task automatic step();
    exp_t e;
    #1;
    if (s_out_valid && !out_ready) holds++;
    if (s_out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_result (width %0d): got sum %h with nothing outstanding",
                 cur_w, s_sum);
      end else begin
        e = q.pop_front();
        chk("sum", s_sum, e.s);
        chk("cout", {31'h0, s_cout}, {31'h0, e.co});
        chk("ovf", {31'h0, s_ovf}, {31'h0, e.ov});
        chk("latency", 32'(cyc - e.cyc), 32'(nstg + holds - e.holds));
      end
    end
    accepted = in_valid && s_in_ready;
    if (accepted) begin
      e.s = exp_s; e.co = exp_co; e.ov = exp_ov; e.cyc = cyc; e.holds = holds;
      q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                        input logic sb, input logic [31:0] es, input logic eco,
                        input logic eov);
    a_d = av; b_d = bv; cin_d = ci; sub_d = sb;
    exp_s = es; exp_co = eco; exp_ov = eov;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 100);
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout (width %0d): got no acceptance, expected one", cur_w);
    end
    in_valid = 1'b0;
  endtask

  task automatic set_model(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                           input logic sb);
    logic [31:0] s;
    logic co, ov;
    model(av, bv, ci, sb, s, co, ov);
    set_op(av & wmask(cur_w), bv & wmask(cur_w), ci, sb, s, co, ov);
  endtask

  task automatic send_model(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                            input logic sb);
    set_model(av, bv, ci, sb);
    wait_accept();
  endtask

  task automatic send_rand();
    send_model($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout (width %0d): got %0d outstanding, expected 0",
               cur_w, q.size());
      q.delete();
    end
  endtask

  task automatic idle(input int n);
    logic seen;
    seen     = 1'b0;
    in_valid = 1'b0;
    repeat (n) begin
      step();
      seen |= s_out_valid;
    end
    chk("idle_out_valid", {31'h0, seen}, 32'h0);
  endtask

  task automatic run_suite();
    logic [31:0] m, snap_s;
    logic snap_co, snap_ov;
    m = wmask(cur_w);

    // Reset with junk on the inputs
    @(negedge clk);
    rst_n = 1'b0;
    set_op($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0, 0);
    out_ready = 1'($urandom_range(1));
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'h0, s_out_valid}, 32'h0);
    chk("rst_sum", s_sum, 32'h0);
    chk("rst_cout", {31'h0, s_cout}, 32'h0);
    chk("rst_ovf", {31'h0, s_ovf}, 32'h0);
    chk("rst_busy", {31'h0, s_busy}, 32'h0);
    chk("rst_in_ready", {31'h0, s_in_ready}, 32'h1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // Directed corners
    if (cur_w == 16) begin
      foreach (tbl[i]) begin
        set_op({16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].cin, tbl[i].sub,
               {16'h0, tbl[i].s}, tbl[i].co, tbl[i].ov);
        wait_accept();
      end
    end else begin
      send_model(m, 32'h1, 1'b0, 1'b0);
      send_model(m >> 1, 32'h1, 1'b0, 1'b0);
      send_model((m >> 1) + 32'h1, 32'h1, 1'b0, 1'b1);
      send_model(32'h0, 32'h1, 1'b1, 1'b1);
      send_model(m, m, 1'b1, 1'b0);
    end
    drain();

    // Back-to-back streaming
    send_rand();
    chk("busy_after_accept", {31'h0, s_busy}, 32'h1);
    repeat (7) send_rand();
    drain();

    // Backpressure: fill, stall five cycles with an op pending, then release
    out_ready = 1'b0;
    repeat (nstg) send_rand();
    set_model($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    snap_s  = s_sum;
    snap_co = s_cout;
    snap_ov = s_ovf;
    repeat (5) begin
      step();
      chk("stall_in_ready", {31'h0, s_in_ready}, 32'h0);
      chk("stall_out_valid", {31'h0, s_out_valid}, 32'h1);
      chk("stall_sum_stable", s_sum, snap_s);
      chk("stall_flags_stable", {30'h0, s_cout, s_ovf}, {30'h0, snap_co, snap_ov});
    end
    out_ready = 1'b1;
    wait_accept();
    repeat (3) send_rand();
    drain();

    // Reset with ops in flight
    repeat (3) send_rand();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, s_out_valid}, 32'h0);
    chk("midrst_busy", {31'h0, s_busy}, 32'h0);
    chk("midrst_sum", s_sum, 32'h0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
  endtask

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[3] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[7] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[9] = '{16'h8000, 16'h0000, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_d = 32'h0; b_d = 32'h0; cin_d = 1'b0; sub_d = 1'b0;
    exp_s = 32'h0; exp_co = 1'b0; exp_ov = 1'b0;
    accepted = 1'b0;
    sel = 0; cur_w = 8; nstg = 1;

    for (int s = 0; s < 3; s++) begin
      sel   = s;
      cur_w = (s == 0) ? 8 : (s == 1) ? 16 : 32;
      nstg  = (s == 0) ? 1 : (s == 1) ? 4 : 8;
      run_suite();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csel_adder_pipe.md
# csel_adder_pipe

Parametrised, pipelined carry-select adder/subtractor: WIDTH-bit operands are split into BLOCK-bit slices, and one slice is resolved per pipeline stage. Each stage precomputes the slice sum for carry-in 0 and carry-in 1, then selects with the registered carry from the stage before. A valid/ready handshake with full-pipeline backpressure wraps the datapath. It is the wide, streaming successor of the team's 4-bit combinational carry-select adder, and feeds accumulator/ALU datapaths that need one result per clock.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of BLOCK.
- BLOCK, 4, slice width in bits; BLOCK ≥ 1.
- NSTG (derived, not overridable), WIDTH/BLOCK, number of pipeline stages.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB.
- ovf  output  1  two's-complement overflow.
- busy  output  1  OR of all stage valid bits.

## Operation
- Effective operands: bb = sub ? ~b : b; c0 = cin ^ sub.
  - sub=0 computes a + b + cin.
  - sub=1 computes a − b − cin, i.e. a + ~b + !cin.
- cout is the raw carry of that sum; for subtract, cout=1 means no borrow.
- ovf = carry into bit WIDTH−1 XOR cout.
- Stage registers R0..R(NSTG−1). Each holds:
  - a valid bit
  - the unresolved upper bits of a and bb
  - the resolved low sum bits
  - the carry out of the last resolved slice
  - the MSB carry-in (last stage only)
- Slice k logic: two ripple adders of BLOCK bits, one with carry-in 0 and one with carry-in 1, produce sum0/c0 and sum1/c1. A 2:1 select on the incoming carry picks the result.
- On acceptance, R0 captures the inputs with slice 0 resolved using c0.
- On each advance, R(k) captures R(k−1) with slice k resolved using R(k−1)'s carry.
- Outputs (sum, cout, ovf, out_valid) are driven directly from R(NSTG−1).
- advance = !out_valid | out_ready; in_ready = advance. The whole pipeline advances or holds together.
- Acceptance occurs when in_valid & in_ready. If in_valid=0 on an advance, a bubble (valid=0) enters R0.
- While stalled (out_valid=1, out_ready=0), all registers hold and the outputs stay stable.
- Ordering is strictly FIFO. Results are never dropped or duplicated.
- No state machine beyond the per-stage valid bits. There is no mode state: sub travels with each operation.

## Timing
- Reset (rst_n=0, asynchronous):
  - Every valid bit and data register clears to 0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0.
  - in_ready=1 (derived: out_valid=0).
- Latency: an operation accepted on edge E appears on the outputs after edge E+NSTG−1, provided no stall occurs.
  - NSTG=1: result visible right after the accepting edge.
  - Default NSTG=4: visible after the 4th edge, counting the accepting edge as the first.
- Throughput: 1 op/cycle while out_ready=1.
- A stall of n cycles delays every in-flight result by exactly n cycles.
- Accept and output on the same edge (full pipeline, out_ready=1, in_valid=1): legal. The oldest result retires and the new op enters R0.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- rst_n asserted mid-operation discards all in-flight ops. After release, the outputs show no stale data.
- Carry chain per stage: at most one BLOCK-bit ripple plus one mux.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: out_valid=0, sum=0, cout=0, ovf=0, busy=0, in_ready=1. After release and 10 idle cycles, out_valid stays 0.
- Add carry wrap: a=0xFFFF, b=0x0001, cin=0, sub=0. Required: after 4 edges, sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001: sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x8000, b=0x0001, sub=1, cin=0. Required: sum=0x7FFF, cout=1, ovf=1. Also a=0x0000, b=0x0001, sub=1, cin=1: sum=0xFFFE, cout=0, ovf=0.
- Streaming: 8 back-to-back random ops with out_ready=1. Required: 8 consecutive out_valid cycles starting 3 cycles after the first acceptance, in order, all matching the reference model.
- Backpressure: fill the pipeline, then hold out_ready=0 for 5 cycles. Required: in_ready=0 and the outputs stay bit-stable. After out_ready=1, all results emerge in order with no loss or duplication.
- Reset mid-flight plus parameter sweep: assert rst_n with 3 ops in flight. Required: out_valid=0 immediately and no stale results afterward. Repeat the full suite at WIDTH=8/BLOCK=8 (latency 1) and WIDTH=32/BLOCK=4 (latency 8).
